// File: rtl/tm_mult_rr_scheduler.sv
// Round-robin front end sharing one truncated W x W multiplier among NREQ lanes.
// Optional exact-product bypass port enabled by TM_EXACT_BYPASS_EN.
module tm_mult_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int W     = 8,
    parameter int K     = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef TM_EXACT_BYPASS_EN
    input  logic                     exact_i,
`endif
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2*W-1:0]           rsp_p,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = $clog2(DEPTH);
    localparam int PRW = 2 * W;
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [PW:0]    count_q, count_d;
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [PRW-1:0] mem_p_q  [DEPTH];
    logic [PRW-1:0] mem_p_d  [DEPTH];
    logic [IDW-1:0] mem_id_q [DEPTH];
    logic [IDW-1:0] mem_id_d [DEPTH];

    logic           found;
    logic [IDW-1:0] win;
    int             idx;
    logic           pop;
    logic           push;
    logic           slot_ok;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [PRW-1:0] a_ext;
    logic [PRW-1:0] b_ext;
    logic [PRW-1:0] p_trunc;
    logic [PRW-1:0] prod;

    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign slot_ok   = (count_q != FULL) | pop;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int o = 0; o < NREQ; o++) begin
            idx = (int'(ptr_q) + o) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign push      = found & slot_ok;
    assign req_ready = push ? (NREQ'(1) << win) : '0;

    assign a_sel   = req_a[win*W +: W];
    assign b_sel   = req_b[win*W +: W];
    assign a_ext   = PRW'(a_sel >> K);
    assign b_ext   = PRW'(b_sel >> K);
    assign p_trunc = (a_ext * b_ext) << (2 * K);

`ifdef TM_EXACT_BYPASS_EN
    logic [PRW-1:0] p_exact;
    assign p_exact = PRW'(a_sel) * PRW'(b_sel);
    assign prod    = exact_i ? p_exact : p_trunc;
`else
    assign prod    = p_trunc;
`endif

    always_comb begin
        ptr_d    = ptr_q;
        count_d  = count_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        mem_p_d  = mem_p_q;
        mem_id_d = mem_id_q;
        if (push) begin
            ptr_d          = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            wr_d           = wr_q + 1'b1;
            mem_p_d[wr_q]  = prod;
            mem_id_d[wr_q] = win;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_p_q[i]  <= '0;
                mem_id_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            mem_p_q  <= mem_p_d;
            mem_id_q <= mem_id_d;
        end
    end

    assign rsp_p  = mem_p_q[rd_q];
    assign rsp_id = mem_id_q[rd_q];
    assign busy   = rsp_valid | (|req_valid);

endmodule
